// File: rtl/core_pkg.sv
// Shared core definitions: operand-B addressing modes and the hard-wired zero register.
package core_pkg;

  // Operand B source select carried by decode.
  localparam logic ADDR_MODE_DIRECT    = 1'b0;
  localparam logic ADDR_MODE_IMMEDIATE = 1'b1;

  // Register index that always reads as zero and is never a forwarding/stall target.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/ofetch_src_resolve.sv
// Per-source operand resolution for the operand fetch stage.
// Detects a RAW match against the EX and WB results and either forwards the
// newest value or raises a stall, depending on the OFETCH_FWD_EN build option:
//   OFETCH_FWD_EN defined   : EX > WB > regfile mux, stall only on load-use.
//   OFETCH_FWD_EN undefined : regfile data only, stall on any EX/WB match.
module ofetch_src_resolve
  import core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RIDX_W = 5
) (
  input  logic              src_en,
  input  logic [RIDX_W-1:0] src_idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_is_load,
  input  logic [RIDX_W-1:0] ex_fwd_idx,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [RIDX_W-1:0] wb_fwd_idx,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [DATA_W-1:0] opnd,
  output logic              hazard
);

  logic is_zero;
  logic ex_match;
  logic wb_match;

  // A source only participates in hazard checks when it is really read and is not r0.
  assign is_zero  = (src_idx == RIDX_W'(REG_ZERO));
  assign ex_match = src_en & ~is_zero & ex_fwd_valid & (src_idx == ex_fwd_idx);
  assign wb_match = src_en & ~is_zero & wb_fwd_valid & (src_idx == wb_fwd_idx);

`ifdef OFETCH_FWD_EN
  // Forwarding mux: r0 forced to zero, then youngest producer (EX) wins over WB.
  always_comb begin
    // NOTE: assign a default first so every path drives opnd and no latch is inferred.
    opnd = rf_data;
    if (is_zero) begin
      opnd = '0;
    end else if (ex_match) begin
      opnd = ex_fwd_data;
    end else if (wb_match) begin
      opnd = wb_fwd_data;
    end
  end

  // A load in EX has no data yet, so its consumer must wait one cycle.
  assign hazard = ex_match & ex_fwd_is_load;
`else
  // Interlock-only: operand always comes from the regfile, r0 forced to zero.
  always_comb begin
    opnd = is_zero ? '0 : rf_data;
  end

  // Any in-flight writer of this source holds decode until it retires.
  assign hazard = ex_match | wb_match;

  // Forwarding data paths are not needed in this build.
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_is_load, ex_fwd_data, wb_fwd_data};
`endif

endmodule

// File: rtl/operand_fetch_pipe.sv
// Operand fetch stage between decode (ID) and execute (EX).
// Reads two regfile sources, picks register or extended immediate for operand B,
// resolves RAW hazards via ofetch_src_resolve and registers the bundle into a
// single valid/ready EX slot. Build option: OFETCH_FWD_EN enables forwarding.
module operand_fetch_pipe
  import core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RIDX_W = 5,
  parameter int IMM_W  = 5,
  parameter int OP_W   = 5,
  parameter int COND_W = 4,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  // decode side
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_op,
  input  logic [COND_W-1:0] id_cond,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_addr_mode,
  input  logic              id_imm_signed,
  input  logic [RIDX_W-1:0] id_idx_a,
  input  logic [RIDX_W-1:0] id_idx_b,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_has_wb,
  // register file read ports
  output logic              rf_en_a,
  output logic              rf_en_b,
  output logic [RIDX_W-1:0] rf_idx_a,
  output logic [RIDX_W-1:0] rf_idx_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  // in-flight results
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_is_load,
  input  logic [RIDX_W-1:0] ex_fwd_idx,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [RIDX_W-1:0] wb_fwd_idx,
  input  logic [DATA_W-1:0] wb_fwd_data,
  // execute side
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [COND_W-1:0] ex_cond,
  output logic [PC_W-1:0]   ex_pc,
  output logic              ex_has_wb,
  output logic [RIDX_W-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_opnd_a,
  output logic [DATA_W-1:0] ex_opnd_b
);

  logic              b_is_reg;
  logic              imm_fill;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b_reg;
  logic [DATA_W-1:0] opnd_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              hazard;
  logic              slot_free;
  logic              xfer;

  // Regfile addressing follows decode directly; B is not read for immediates.
  assign b_is_reg = (id_addr_mode == ADDR_MODE_DIRECT);
  assign rf_idx_a = id_idx_a;
  assign rf_idx_b = id_idx_b;
  assign rf_en_a  = id_valid;
  assign rf_en_b  = id_valid & b_is_reg;

  // Immediate widened with its sign bit or with zeros.
  assign imm_fill = id_imm_signed & id_imm[IMM_W-1];
  assign imm_ext  = {{(DATA_W-IMM_W){imm_fill}}, id_imm};

  ofetch_src_resolve #(.DATA_W(DATA_W), .RIDX_W(RIDX_W)) u_src_a (
    .src_en         (1'b1),
    .src_idx        (id_idx_a),
    .rf_data        (rf_data_a),
    .ex_fwd_valid   (ex_fwd_valid),
    .ex_fwd_is_load (ex_fwd_is_load),
    .ex_fwd_idx     (ex_fwd_idx),
    .ex_fwd_data    (ex_fwd_data),
    .wb_fwd_valid   (wb_fwd_valid),
    .wb_fwd_idx     (wb_fwd_idx),
    .wb_fwd_data    (wb_fwd_data),
    .opnd           (opnd_a),
    .hazard         (hazard_a)
  );

  ofetch_src_resolve #(.DATA_W(DATA_W), .RIDX_W(RIDX_W)) u_src_b (
    .src_en         (b_is_reg),
    .src_idx        (id_idx_b),
    .rf_data        (rf_data_b),
    .ex_fwd_valid   (ex_fwd_valid),
    .ex_fwd_is_load (ex_fwd_is_load),
    .ex_fwd_idx     (ex_fwd_idx),
    .ex_fwd_data    (ex_fwd_data),
    .wb_fwd_valid   (wb_fwd_valid),
    .wb_fwd_idx     (wb_fwd_idx),
    .wb_fwd_data    (wb_fwd_data),
    .opnd           (opnd_b_reg),
    .hazard         (hazard_b)
  );

  assign opnd_b = b_is_reg ? opnd_b_reg : imm_ext;

  // Slot accepts when empty or draining this cycle, and no source is blocked.
  assign hazard    = hazard_a | hazard_b;
  assign slot_free = ~ex_valid | ex_ready;
  assign id_ready  = slot_free & ~hazard;
  assign xfer      = id_valid & id_ready;

  // EX slot: load on transfer, hold under back-pressure, empty on drain without fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_cond   <= '0;
      ex_pc     <= '0;
      ex_has_wb <= 1'b0;
      ex_dst    <= '0;
      ex_opnd_a <= '0;
      ex_opnd_b <= '0;
    end else if (xfer) begin
      ex_valid  <= 1'b1;
      ex_op     <= id_op;
      ex_cond   <= id_cond;
      ex_pc     <= id_pc;
      ex_has_wb <= id_has_wb;
      ex_dst    <= id_idx_a;
      ex_opnd_a <= opnd_a;
      ex_opnd_b <= opnd_b;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Self-checking bench for operand_fetch_pipe: a table of single-transfer vectors
// plus hand-written sequences for reset, back-pressure and hazard behaviour.
// Expectations follow the OFETCH_FWD_EN build option when it is defined.
module tb_operand_fetch_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [4:0]  id_op;
  logic [3:0]  id_cond;
  logic [15:0] id_pc;
  logic        id_addr_mode, id_imm_signed;
  logic [4:0]  id_idx_a, id_idx_b, id_imm;
  logic        id_has_wb;
  logic        rf_en_a, rf_en_b;
  logic [4:0]  rf_idx_a, rf_idx_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic        ex_fwd_valid, ex_fwd_is_load;
  logic [4:0]  ex_fwd_idx;
  logic [15:0] ex_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_idx;
  logic [15:0] wb_fwd_data;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_op;
  logic [3:0]  ex_cond;
  logic [15:0] ex_pc;
  logic        ex_has_wb;
  logic [4:0]  ex_dst;
  logic [15:0] ex_opnd_a, ex_opnd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_pipe dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_cond(id_cond), .id_pc(id_pc),
    .id_addr_mode(id_addr_mode), .id_imm_signed(id_imm_signed),
    .id_idx_a(id_idx_a), .id_idx_b(id_idx_b), .id_imm(id_imm),
    .id_has_wb(id_has_wb),
    .rf_en_a(rf_en_a), .rf_en_b(rf_en_b),
    .rf_idx_a(rf_idx_a), .rf_idx_b(rf_idx_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_cond(ex_cond), .ex_pc(ex_pc),
    .ex_has_wb(ex_has_wb), .ex_dst(ex_dst),
    .ex_opnd_a(ex_opnd_a), .ex_opnd_b(ex_opnd_b)
  );

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  cond;
    logic [15:0] pc;
    logic        mode;
    logic        sgn;
    logic [4:0]  idx_a;
    logic [4:0]  idx_b;
    logic [4:0]  imm;
    logic        has_wb;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic        exf_v;
    logic [4:0]  exf_idx;
    logic        wbf_v;
    logic [4:0]  wbf_idx;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_en_b;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_op = 0; id_cond = 0; id_pc = 0;
    id_addr_mode = 0; id_imm_signed = 0; id_idx_a = 0; id_idx_b = 0;
    id_imm = 0; id_has_wb = 0; rf_data_a = 0; rf_data_b = 0;
    ex_fwd_valid = 0; ex_fwd_is_load = 0; ex_fwd_idx = 0; ex_fwd_data = 16'hDEAD;
    wb_fwd_valid = 0; wb_fwd_idx = 0; wb_fwd_data = 16'hCAFE;
    ex_ready = 1;
  endtask

  task automatic apply(input vec_t v);
    id_valid = 1; id_op = v.op; id_cond = v.cond; id_pc = v.pc;
    id_addr_mode = v.mode; id_imm_signed = v.sgn;
    id_idx_a = v.idx_a; id_idx_b = v.idx_b; id_imm = v.imm; id_has_wb = v.has_wb;
    rf_data_a = v.rf_a; rf_data_b = v.rf_b;
    ex_fwd_valid = v.exf_v; ex_fwd_is_load = 0; ex_fwd_idx = v.exf_idx; ex_fwd_data = 16'hDEAD;
    wb_fwd_valid = v.wbf_v; wb_fwd_idx = v.wbf_idx; wb_fwd_data = 16'hCAFE;
  endtask

  // Simple transfer with a fixed operand set, used by the hand-written sequences.
  task automatic set_simple(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] b);
    idle_inputs();
    id_valid = 1; id_op = 5'd3; id_cond = 4'd1; id_pc = pc;
    id_idx_a = 5'd1; id_idx_b = 5'd2; rf_data_a = a; rf_data_b = b; id_has_wb = 1;
  endtask

  initial begin
    //             op    cond  pc        mode sgn idx_a  idx_b  imm        wb  rf_a      rf_b      exv idx    wbv idx    exp_a     exp_b     en_b
    vecs[0] = '{5'd1,  4'd2, 16'h0100, 0,   0,  5'd1,  5'd2,  5'd0,      1, 16'h1111, 16'h2222, 0,  5'd0,  0,  5'd0,  16'h1111, 16'h2222, 1};
    vecs[1] = '{5'd2,  4'd0, 16'h0102, 1,   1,  5'd4,  5'd6,  5'b11100,  1, 16'h0A0A, 16'h7777, 0,  5'd0,  0,  5'd0,  16'h0A0A, 16'hFFFC, 0};
    vecs[2] = '{5'd2,  4'd0, 16'h0104, 1,   0,  5'd4,  5'd6,  5'b11100,  1, 16'h0A0A, 16'h7777, 0,  5'd0,  0,  5'd0,  16'h0A0A, 16'h001C, 0};
    vecs[3] = '{5'd7,  4'd5, 16'h0106, 1,   1,  5'd8,  5'd0,  5'b01111,  0, 16'h0808, 16'h0000, 0,  5'd0,  0,  5'd0,  16'h0808, 16'h000F, 0};
    vecs[4] = '{5'd9,  4'd3, 16'h0108, 0,   0,  5'd0,  5'd5,  5'd0,      0, 16'hFFFF, 16'h5555, 1,  5'd0,  0,  5'd0,  16'h0000, 16'h5555, 1};
    vecs[5] = '{5'd10, 4'd4, 16'h010A, 0,   0,  5'd13, 5'd0,  5'd0,      1, 16'h1313, 16'hFFFF, 0,  5'd0,  1,  5'd0,  16'h1313, 16'h0000, 1};
    vecs[6] = '{5'd11, 4'd6, 16'h010C, 1,   1,  5'd2,  5'd9,  5'b10000,  1, 16'h0202, 16'h9999, 1,  5'd9,  1,  5'd9,  16'h0202, 16'hFFF0, 0};
    vecs[7] = '{5'd31, 4'd15,16'hFFFE, 0,   0,  5'd11, 5'd12, 5'd0,      1, 16'hABCD, 16'h1234, 1,  5'd10, 1,  5'd14, 16'hABCD, 16'h1234, 1};

    // Reset state
    idle_inputs();
    reset = 0;
    #1;
    check("reset_ex_valid", ex_valid, 0);
    check("reset_opnd_a", ex_opnd_a, 0);
    check("reset_opnd_b", ex_opnd_b, 0);
    @(posedge clk); #2;
    reset = 1;
    @(negedge clk);

    // Table-driven single transfers
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_id_ready", i), id_ready, 1);
      check($sformatf("v%0d_rf_en_b", i), rf_en_b, vecs[i].exp_en_b);
      check($sformatf("v%0d_rf_idx_a", i), rf_idx_a, vecs[i].idx_a);
      @(posedge clk); #1;
      check($sformatf("v%0d_ex_valid", i), ex_valid, 1);
      check($sformatf("v%0d_opnd_a", i), ex_opnd_a, vecs[i].exp_a);
      check($sformatf("v%0d_opnd_b", i), ex_opnd_b, vecs[i].exp_b);
      check($sformatf("v%0d_op", i), ex_op, vecs[i].op);
      check($sformatf("v%0d_cond", i), ex_cond, vecs[i].cond);
      check($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
      check($sformatf("v%0d_has_wb", i), ex_has_wb, vecs[i].has_wb);
      check($sformatf("v%0d_dst", i), ex_dst, vecs[i].idx_a);
    end

    // Drain with no new entry empties the slot
    idle_inputs();
    @(posedge clk); #1;
    check("drain_ex_valid", ex_valid, 0);

    // Back-pressure: hold for two cycles, then simultaneous drain and fill
    set_simple(16'h0200, 16'hAAAA, 16'hBBBB);
    @(posedge clk); #1;
    check("bp_load_valid", ex_valid, 1);
    set_simple(16'h0204, 16'hCCCC, 16'hDDDD);
    ex_ready = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("bp%0d_id_ready", c), id_ready, 0);
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), ex_valid, 1);
      check($sformatf("bp%0d_pc", c), ex_pc, 16'h0200);
      check($sformatf("bp%0d_opnd_a", c), ex_opnd_a, 16'hAAAA);
      check($sformatf("bp%0d_opnd_b", c), ex_opnd_b, 16'hBBBB);
    end
    ex_ready = 1;
    #1;
    check("bp_release_id_ready", id_ready, 1);
    @(posedge clk); #1;
    check("bp_fill_valid", ex_valid, 1);
    check("bp_fill_pc", ex_pc, 16'h0204);
    check("bp_fill_opnd_a", ex_opnd_a, 16'hCCCC);
    idle_inputs();
    @(posedge clk); #1;

    // EX result (not a load) targeting source A
    idle_inputs();
    id_valid = 1; id_idx_a = 5'd3; id_idx_b = 5'd4; rf_data_a = 16'h0003; rf_data_b = 16'h0004;
    ex_fwd_valid = 1; ex_fwd_idx = 5'd3; ex_fwd_data = 16'h1234;
    #1;
`ifdef OFETCH_FWD_EN
    check("exfwd_id_ready", id_ready, 1);
    @(posedge clk); #1;
    check("exfwd_opnd_a", ex_opnd_a, 16'h1234);
`else
    check("exfwd_stall0", id_ready, 0);
    @(posedge clk); #1;
    check("exfwd_stall_valid", ex_valid, 0);
    check("exfwd_stall1", id_ready, 0);
    @(posedge clk); #1;
    ex_fwd_valid = 0;
    #1;
    check("exfwd_release", id_ready, 1);
    @(posedge clk); #1;
    check("exfwd_opnd_a", ex_opnd_a, 16'h0003);
`endif
    check("exfwd_valid", ex_valid, 1);
    idle_inputs();
    @(posedge clk); #1;

    // Load-use on source B, then the loaded value arrives from WB
    idle_inputs();
    id_valid = 1; id_idx_a = 5'd1; id_idx_b = 5'd7; rf_data_a = 16'h0001; rf_data_b = 16'h0007;
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_idx = 5'd7;
    #1;
    check("lu_stall", id_ready, 0);
    @(posedge clk); #1;
    check("lu_stall_valid", ex_valid, 0);
    ex_fwd_valid = 0; ex_fwd_is_load = 0;
    wb_fwd_valid = 1; wb_fwd_idx = 5'd7; wb_fwd_data = 16'hBEEF;
    #1;
`ifdef OFETCH_FWD_EN
    check("lu_wb_id_ready", id_ready, 1);
    @(posedge clk); #1;
    check("lu_opnd_b", ex_opnd_b, 16'hBEEF);
`else
    check("lu_wb_stall", id_ready, 0);
    @(posedge clk); #1;
    wb_fwd_valid = 0;
    #1;
    check("lu_wb_release", id_ready, 1);
    @(posedge clk); #1;
    check("lu_opnd_b", ex_opnd_b, 16'h0007);
`endif
    check("lu_valid", ex_valid, 1);
    check("lu_opnd_a", ex_opnd_a, 16'h0001);
    idle_inputs();
    @(posedge clk); #1;

    // Reset asserted mid-transfer, held across an edge with decode still valid
    set_simple(16'h0300, 16'h3333, 16'h4444);
    @(posedge clk); #1;
    check("rst_pre_valid", ex_valid, 1);
    set_simple(16'h0304, 16'h5555, 16'h6666);
    #2;
    reset = 0;
    #1;
    check("rst_async_valid", ex_valid, 0);
    check("rst_async_opnd_a", ex_opnd_a, 0);
    check("rst_async_opnd_b", ex_opnd_b, 0);
    @(posedge clk); #1;
    check("rst_held_valid", ex_valid, 0);
    check("rst_held_opnd_a", ex_opnd_a, 0);
    check("rst_held_opnd_b", ex_opnd_b, 0);
    #2;
    reset = 1;
    @(posedge clk); #1;
    check("rst_after_valid", ex_valid, 1);
    check("rst_after_opnd_a", ex_opnd_a, 16'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
